// File: rtl/tx_fifo_sched_pkg.sv
// tx_fifo_sched_pkg: shared state encoding, word layout and idle fill word for the TX FIFO read scheduler
package tx_fifo_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;
  localparam int DATA_W = 256;
  localparam int CTRL_W = 6;
  localparam int WORD_W = 2 + CTRL_W + DATA_W;
  localparam int SOF_BIT = WORD_W - 1;
  localparam int EOF_BIT = WORD_W - 2;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF = {8'h00, {32{8'h07}}};
endpackage

// File: rtl/tx_fifo_rd_sched_sat_counter.sv
// sat_counter: increment-enabled counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/tx_fifo_rd_sched.sv
// tx_fifo_rd_sched: pops the TX CDC FIFO after a prefill window and streams framed words, idling and draining on underrun
module tx_fifo_rd_sched
  import tx_fifo_sched_pkg::*;
#(
  parameter int               DSIZE       = WORD_W,
  parameter int               PREFILL_CYC = 4,
  parameter logic [DSIZE-1:0] IDLE_WORD   = IDLE_WORD_DEF,
  parameter int               CNT_W       = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             tx_ready,
  output logic [DSIZE-1:0] tx_data,
  output logic             tx_valid,
  output logic             tx_idle,
  output logic             underrun_pulse,
  output logic             stray_pulse,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [1:0]       state_o
);
  localparam int PW = $clog2(PREFILL_CYC) + 1;
  state_t state, state_nxt;
  logic in_frame, in_frame_nxt, load_en, sof, eof, pop, take, stray, under;
  logic [PW-1:0] pcnt;
  always_comb begin
    load_en = tx_ready | ~tx_valid;
    sof = rdata[SOF_BIT];
    eof = rdata[EOF_BIT];
    pop = load_en & ~rempty & ~rrst & ((state == STREAM) | (state == DRAIN));
    take = pop & (state == STREAM) & (in_frame | sof);
    stray = pop & (state == STREAM) & ~in_frame & ~sof;
    under = load_en & (state == STREAM) & rempty & in_frame;
    // eof wins over sof, so a sof+eof word is a complete single-word frame
    in_frame_nxt = take ? ~eof : (pop & eof) ? 1'b0 : in_frame;
    rinc = pop;
    state_nxt = (state == IDLE)    ? (enable ? PREFILL : IDLE) :
                (state == PREFILL) ? (!enable ? IDLE :
                                      (!rempty && pcnt == PW'(PREFILL_CYC - 1)) ? STREAM : PREFILL) :
                (state == STREAM)  ? (under ? DRAIN :
                                      (load_en && !enable && !in_frame_nxt) ? IDLE : STREAM) :
                                     ((pop && eof) ? PREFILL : DRAIN);
  end
  always_ff @(posedge rclk)
    if (rrst) begin
      state <= IDLE;
      in_frame <= 1'b0;
      tx_data <= IDLE_WORD;
      tx_valid <= 1'b0;
      tx_idle <= 1'b1;
      underrun_pulse <= 1'b0;
      stray_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      in_frame <= in_frame_nxt;
      underrun_pulse <= under;
      stray_pulse <= stray;
      if (load_en) begin
        tx_data <= take ? rdata : IDLE_WORD;
        tx_valid <= state != IDLE;
        tx_idle <= ~take;
      end
    end
  // prefill count restarts whenever the FIFO reads empty or we leave PREFILL
  sat_counter #(.W(PW)) u_pre (
    .clk(rclk),
    .clr(rrst | (state != PREFILL) | rempty),
    .inc(1'b1),
    .cnt(pcnt)
  );
  sat_counter #(.W(CNT_W)) u_ur (
    .clk(rclk),
    .clr(rrst),
    .inc(under),
    .cnt(underrun_cnt)
  );
  assign state_o = state;
endmodule

// File: tb/tb_tx_fifo_rd_sched.sv
// tb_tx_fifo_rd_sched: FIFO stimulus model with a word scoreboard, table-driven frame scenarios and hand-written corner sequences
module tb_tx_fifo_rd_sched;
  localparam logic [263:0] IDLE = {8'h00, {32{8'h07}}};
  typedef struct {
    string      name;
    int         nwords;
    int         stall_len;
    int         starve_after;
    bit         stray;
    int         exp_deliv;
    int         exp_ur;
    int         exp_st;
    logic [1:0] exp_state;
  } vec_t;
  logic rclk = 1'b0;
  logic rrst, enable, rempty, tx_ready;
  logic [263:0] rdata, tx_data, sat_data;
  logic rinc, tx_valid, tx_idle, underrun_pulse, stray_pulse;
  logic [15:0] underrun_cnt;
  logic [1:0] state_o;
  logic sat_rinc, sat_valid, sat_idle, sat_ur, sat_st;
  logic [1:0] sat_cnt, sat_state;
  logic [263:0] fifo[$], exp_q[$];
  int tests, fails, delivered, n_ur, n_st, pops, stall_trig, stall_left;
  int d0, u0, t0, cyc_n;
  bit s_rinc, s_ur, s_sat_ur, prev_stall, done, sp;
  logic [1:0] s_sat_cnt, sc;
  logic [263:0] prev_data;
  vec_t vecs[4];

  always #5 rclk = ~rclk;

  tx_fifo_rd_sched dut (
    .rclk(rclk), .rrst(rrst), .enable(enable), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_idle(tx_idle),
    .underrun_pulse(underrun_pulse), .stray_pulse(stray_pulse), .underrun_cnt(underrun_cnt),
    .state_o(state_o)
  );
  tx_fifo_rd_sched #(.CNT_W(2)) u_sat (
    .rclk(rclk), .rrst(rrst), .enable(enable), .rempty(rempty), .rdata(rdata), .rinc(sat_rinc),
    .tx_ready(tx_ready), .tx_data(sat_data), .tx_valid(sat_valid), .tx_idle(sat_idle),
    .underrun_pulse(sat_ur), .stray_pulse(sat_st), .underrun_cnt(sat_cnt), .state_o(sat_state)
  );

  task automatic check(string name, logic [263:0] got, logic [263:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [263:0] mk(bit sof, bit eof, int idx);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(idx);
    return {sof, eof, 6'(idx), {8{w}}};
  endfunction

  task automatic drive();
    rempty = (fifo.size() == 0);
    rdata = rempty ? '0 : fifo[0];
  endtask

  task automatic push(logic [263:0] w, bit ex);
    fifo.push_back(w);
    if (ex) exp_q.push_back(w);
    drive();
  endtask

  task automatic tick();
    @(negedge rclk);
    s_rinc = rinc;
    s_ur = underrun_pulse;
    s_sat_ur = sat_ur;
    s_sat_cnt = sat_cnt;
    if (rinc && rempty) check("pop_on_empty", 1, 0);
    if (tx_valid && !tx_idle && tx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %h expected no data word", tx_data);
      end else check("sb_word", tx_data, exp_q.pop_front());
      delivered++;
    end
    if (stray_pulse || underrun_pulse) check("pulse_idle_word", tx_data, IDLE);
    if (!tx_ready && tx_valid) check("stall_no_pop", rinc, 0);
    if (prev_stall) check("stall_hold", tx_data, prev_data);
    prev_stall = !tx_ready && tx_valid === 1'b1;
    prev_data = tx_data;
    if (underrun_pulse) n_ur++;
    if (stray_pulse) n_st++;
    @(posedge rclk);
    #1;
    if (s_rinc && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    if (stall_left > 0 && delivered >= stall_trig) begin
      tx_ready = 1'b0;
      stall_left--;
    end else tx_ready = 1'b1;
    drive();
  endtask

  task automatic underrun_seq(int idx, output bit sat_pulse, output logic [1:0] sat_c);
    int u_base;
    bit ok;
    u_base = n_ur;
    ok = 0;
    sat_pulse = 0;
    sat_c = '0;
    push(mk(1, 0, idx), 1);
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      ok = (n_ur != u_base);
    end
    check("useq_pulse", ok, 1);
    sat_pulse = s_sat_ur;
    sat_c = s_sat_cnt;
    push(mk(0, 1, idx + 1), 0);
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      ok = (state_o == 2'd1);
    end
    check("useq_prefill", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"stall", 5, 3, -1, 0, 5, 0, 0, 2'd2};
    vecs[1] = '{"starve", 4, 0, 1, 0, 2, 1, 0, 2'd1};
    vecs[2] = '{"stray", 3, 0, -1, 1, 3, 0, 1, 2'd2};
    vecs[3] = '{"single", 1, 0, -1, 0, 1, 0, 0, 2'd2};
    rrst = 1'b1;
    enable = 1'b0;
    tx_ready = 1'b1;
    push(mk(1, 0, 1), 0);
    push(mk(0, 0, 2), 0);
    push(mk(0, 1, 3), 0);
    repeat (3) tick();
    check("rst_state", state_o, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_idle", tx_idle, 1);
    check("rst_data", tx_data, IDLE);
    check("rst_cnt", underrun_cnt, 0);
    check("rst_rinc", rinc, 0);
    rrst = 1'b0;
    repeat (5) tick();
    check("disabled_no_pop", pops, 0);
    check("disabled_valid", tx_valid, 0);
    fifo.delete();
    drive();

    enable = 1'b1;
    for (int i = 0; i < 5; i++) push(mk(i == 0, i == 4, i), 1);
    cyc_n = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = s_rinc;
      if (!done) cyc_n++;
    end
    check("first_rinc_cycle", cyc_n, 5);
    repeat (5) tick();
    check("frame_consecutive", delivered, 5);
    tick();
    check("post_frame_idle", tx_idle, 1);
    check("post_frame_valid", tx_valid, 1);

    d0 = delivered;
    push(mk(1, 0, 20), 1);
    push(mk(0, 0, 21), 1);
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = s_ur;
    end
    check("ur_seen", done, 1);
    check("ur_state", state_o, 3);
    check("ur_cnt", underrun_cnt, 1);
    push(mk(0, 0, 22), 0);
    push(mk(0, 1, 23), 0);
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      done = (state_o == 2'd1);
    end
    check("ur_to_prefill", done, 1);
    check("ur_deliv", delivered - d0, 2);
    check("ur_drained", fifo.size(), 0);

    for (int v = 0; v < 4; v++) begin
      d0 = delivered;
      u0 = n_ur;
      t0 = n_st;
      if (vecs[v].stray) push(mk(0, 0, 40 + v), 0);
      stall_trig = delivered + 1;
      stall_left = vecs[v].stall_len;
      for (int i = 0; i < vecs[v].nwords; i++) begin
        if (vecs[v].starve_after >= 0 && i == vecs[v].starve_after + 1) repeat (8) tick();
        push(mk(i == 0, i == vecs[v].nwords - 1, 100 + 10 * v + i),
             vecs[v].starve_after < 0 || i <= vecs[v].starve_after);
      end
      repeat (30) tick();
      check({vecs[v].name, "_deliv"}, delivered - d0, vecs[v].exp_deliv);
      check({vecs[v].name, "_underruns"}, n_ur - u0, vecs[v].exp_ur);
      check({vecs[v].name, "_strays"}, n_st - t0, vecs[v].exp_st);
      check({vecs[v].name, "_state"}, state_o, vecs[v].exp_state);
    end
    check("cnt_after_table", underrun_cnt, 2);

    underrun_seq(60, sp, sc);
    check("sat_reach_max", sc, 3);
    underrun_seq(70, sp, sc);
    check("sat_hold_max", sc, 3);
    check("sat_pulse_fires", sp, 1);
    check("wide_cnt", underrun_cnt, 4);
    check("sb_empty", exp_q.size(), 0);

    d0 = delivered;
    push(mk(1, 0, 80), 1);
    push(mk(0, 0, 81), 1);
    push(mk(0, 1, 82), 1);
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      done = (delivered != d0);
    end
    check("midframe_started", done, 1);
    rrst = 1'b1;
    tick();
    check("rst_cycle_no_pop", s_rinc, 0);
    tick();
    check("midrst_state", state_o, 0);
    check("midrst_valid", tx_valid, 0);
    check("midrst_idle", tx_idle, 1);
    check("midrst_cnt", underrun_cnt, 0);
    rrst = 1'b0;
    fifo.delete();
    exp_q.delete();
    drive();
    t0 = n_st;
    push(mk(0, 0, 90), 0);
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      done = (n_st != t0);
    end
    check("midrst_inframe_clear", done, 1);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
